// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: serial pattern detector with an IDLE/ARMED/DONE controller.
// Optional feature macro: PDC_TIMEOUT_EN. When defined, an ARMED run also ends in
// DONE with timeout=1 after TIMEOUT_BITS valid bits without a match. When it is
// undefined, no timeout counter is built and timeout is tied to 0.
module pattern_det_ctrl #(
    parameter int          TIMEOUT_BITS = 64,
    parameter logic [4:0]  RST_PATTERN  = 5'b11011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [4:0] cfg_pattern,
    input  logic [2:0] cfg_len,
    input  logic       cfg_overlap,
    input  logic [7:0] cfg_target,
    input  logic       start,
    input  logic       abort,
    input  logic       data_valid,
    input  logic       data_in,
    output logic       busy,
    output logic       done,
    output logic       match_pulse,
    output logic [7:0] match_count,
    output logic       cfg_err,
    output logic       aborted,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

    state_t     state_q;
    logic       busy_q, done_q, match_pulse_q, cfg_err_q, aborted_q, timeout_q;
    logic [7:0] match_count_q;
    logic [4:0] hist_q;
    logic [2:0] fill_q;
    logic [4:0] pat_q;
    logic [2:0] len_q;
    logic       ovl_q;
    logic [7:0] tgt_q;

    logic [4:0] hist_d;
    logic [2:0] fill_d;
    logic [7:0] match_count_d;
    logic [5:0] mask6;
    logic       hit;
    logic       cfg_ok;

`ifdef PDC_TIMEOUT_EN
    logic [15:0] tcnt_q;
    logic [15:0] tcnt_d;
    logic        tcnt_exp;
`endif

    // Candidate history/fill including the current bit, and the match decision on it.
    always_comb begin
        hist_d        = {hist_q[3:0], data_in};
        fill_d        = (fill_q >= 3'd5) ? 3'd5 : fill_q + 3'd1;
        mask6         = (6'd1 << len_q) - 6'd1;
        hit           = (fill_d >= len_q) && (((hist_d ^ pat_q) & mask6[4:0]) == 5'd0);
        match_count_d = match_count_q + 8'd1;
        // Start is judged against the config already registered, not the one being written.
        cfg_ok        = (len_q != 3'd0) && (len_q <= 3'd5) && (tgt_q != 8'd0);
`ifdef PDC_TIMEOUT_EN
        tcnt_d        = tcnt_q + 16'd1;
        tcnt_exp      = (tcnt_d == 16'(TIMEOUT_BITS));
`endif
    end

    // Controller FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            match_pulse_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            aborted_q     <= 1'b0;
            timeout_q     <= 1'b0;
            match_count_q <= 8'd0;
            hist_q        <= 5'd0;
            fill_q        <= 3'd0;
            pat_q         <= RST_PATTERN;
            len_q         <= 3'd5;
            ovl_q         <= 1'b1;
            tgt_q         <= 8'd1;
`ifdef PDC_TIMEOUT_EN
            tcnt_q        <= 16'd0;
`endif
        end else begin
            match_pulse_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // abort outranks a simultaneous start, even though abort alone is a no-op here.
                    if (start && !abort) begin
                        if (cfg_ok) begin
                            state_q       <= ARMED;
                            busy_q        <= 1'b1;
                            done_q        <= 1'b0;
                            match_count_q <= 8'd0;
                            hist_q        <= 5'd0;
                            fill_q        <= 3'd0;
                            aborted_q     <= 1'b0;
                            timeout_q     <= 1'b0;
`ifdef PDC_TIMEOUT_EN
                            tcnt_q        <= 16'd0;
`endif
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                        tgt_q <= cfg_target;
                    end
                end
                ARMED: begin
                    if (abort) begin
                        // Abort wins over any match completing on this cycle.
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (data_valid) begin
                        hist_q <= hist_d;
                        if (hit) begin
                            match_pulse_q <= 1'b1;
                            match_count_q <= match_count_d;
                            fill_q        <= ovl_q ? fill_d : 3'd0;
`ifdef PDC_TIMEOUT_EN
                            tcnt_q        <= 16'd0;
`endif
                            if (match_count_d == tgt_q) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            fill_q <= fill_d;
`ifdef PDC_TIMEOUT_EN
                            tcnt_q <= tcnt_d;
                            if (tcnt_exp) begin
                                state_q   <= DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                timeout_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign match_pulse = match_pulse_q;
    assign match_count = match_count_q;
    assign cfg_err     = cfg_err_q;
    assign aborted     = aborted_q;
`ifdef PDC_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: directed scenarios plus randomized traffic, all checked
// against a bit-queue reference model of the detector.
module tb_pattern_det_ctrl;

`ifdef PDC_TIMEOUT_EN
    localparam int TO_BITS = 8;
`else
    localparam int TO_BITS = 64;
`endif

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_overlap, start, abort, data_valid, data_in;
    logic [4:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic [7:0] cfg_target;
    logic       busy, done, match_pulse, cfg_err, aborted, timeout;
    logic [7:0] match_count;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    int         m_st;        // 0 idle, 1 armed, 2 done
    logic [4:0] m_pat;
    int         m_len, m_tgt, m_cnt, m_bits, m_tc;
    logic       m_ov, m_pulse, m_err, m_ab, m_to;
    bit         m_q[$];

    pattern_det_ctrl #(.TIMEOUT_BITS(TO_BITS), .RST_PATTERN(5'b11011)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .data_valid(data_valid), .data_in(data_in),
        .busy(busy), .done(done), .match_pulse(match_pulse),
        .match_count(match_count), .cfg_err(cfg_err), .aborted(aborted),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Next-state of the model from the inputs presented this cycle.
    task automatic model_update();
        bit ok;
        if (rst) begin
            m_st = 0; m_pat = 5'b11011; m_len = 5; m_ov = 1; m_tgt = 1;
            m_cnt = 0; m_bits = 0; m_tc = 0; m_pulse = 0; m_err = 0;
            m_ab = 0; m_to = 0; m_q.delete();
            return;
        end
        m_pulse = 0;
        m_err   = 0;
        if (m_st != 1) begin
            if (start && !abort) begin
                if (m_len < 1 || m_len > 5 || m_tgt == 0) m_err = 1;
                else begin
                    m_st = 1; m_cnt = 0; m_bits = 0; m_tc = 0;
                    m_ab = 0; m_to = 0; m_q.delete();
                end
            end
            if (cfg_we) begin
                m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap; m_tgt = cfg_target;
            end
        end else if (abort) begin
            m_st = 0; m_ab = 1;
        end else if (data_valid) begin
            m_q.push_back(data_in);
            if (m_q.size() > 8) void'(m_q.pop_front());
            m_bits++;
            ok = (m_bits >= m_len);
            for (int i = 0; i < m_len && ok; i++)
                if (m_q[m_q.size() - 1 - i] != m_pat[i]) ok = 0;
            if (ok) begin
                m_cnt++; m_pulse = 1; m_tc = 0;
                if (!m_ov) m_bits = 0;
                if (m_cnt == m_tgt) m_st = 2;
            end else begin
`ifdef PDC_TIMEOUT_EN
                m_tc++;
                if (m_tc == TO_BITS) begin m_st = 2; m_to = 1; end
`endif
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("busy", busy, (m_st == 1));
        chk("done", done, (m_st == 2));
        chk("pulse", match_pulse, m_pulse);
        chk("count", match_count, m_cnt[7:0]);
        chk("cfg_err", cfg_err, m_err);
        chk("aborted", aborted, m_ab);
        chk("timeout", timeout, m_to);
        rst = 0; cfg_we = 0; start = 0; abort = 0; data_valid = 0; data_in = 0;
    endtask

    task automatic cfg(input logic [4:0] p, input logic [2:0] l, input logic o, input logic [7:0] t);
        cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        step();
    endtask

    task automatic do_start();
        start = 1;
        step();
    endtask

    task automatic bit_in(input logic b);
        data_valid = 1; data_in = b;
        step();
    endtask

    initial begin
        logic [7:0] s8;
        rst = 1; cfg_we = 0; start = 0; abort = 0; data_valid = 0; data_in = 0;
        cfg_pattern = 5'd0; cfg_len = 3'd0; cfg_overlap = 0; cfg_target = 8'd0;
        step();
        rst = 1; step();
        chk("rst_busy", busy, 0);
        chk("rst_cnt", match_count, 0);

        // defaults: 1,1,0,1,1 finishes after one match
        do_start();
        chk("d1_busy", busy, 1);
        s8 = 8'b11011;
        for (int i = 4; i >= 0; i--) bit_in(s8[i]);
        chk("d1_pulse", match_pulse, 1);
        chk("d1_cnt", match_count, 1);
        chk("d1_done", done, 1);
        chk("d1_busy0", busy, 0);

        // overlap, target 2: matches after bits 5 and 8
        cfg(5'b11011, 3'd5, 1, 8'd2);
        do_start();
        s8 = 8'b11011011;
        for (int i = 7; i >= 0; i--) begin
            bit_in(s8[i]);
            if (i == 3) chk("d2_p5", match_pulse, 1);
        end
        chk("d2_p8", match_pulse, 1);
        chk("d2_cnt", match_count, 2);
        chk("d2_done", done, 1);

        // no overlap: one match only, still armed
        cfg(5'b11011, 3'd5, 0, 8'd2);
        do_start();
        for (int i = 7; i >= 0; i--) bit_in(s8[i]);
        chk("d3_cnt", match_count, 1);
        chk("d3_busy", busy, 1);
        abort = 1; step();
        chk("d3_ab", aborted, 1);

        // illegal configs rejected; cfg writes while armed ignored
        cfg(5'b11011, 3'd0, 1, 8'd1);
        do_start();
        chk("d4_err_len", cfg_err, 1);
        chk("d4_idle", busy, 0);
        cfg(5'b11011, 3'd5, 1, 8'd0);
        do_start();
        chk("d4_err_tgt", cfg_err, 1);
        cfg(5'b11011, 3'd5, 1, 8'd1);
        do_start();
        cfg(5'b00000, 3'd2, 0, 8'd9);
        s8 = 8'b11011;
        for (int i = 4; i >= 0; i--) bit_in(s8[i]);
        chk("d4_keep", match_count, 1);
        chk("d4_done", done, 1);

        // abort on the completing bit of the final match
        do_start();
        for (int i = 4; i >= 1; i--) bit_in(s8[i]);
        data_valid = 1; data_in = 1; abort = 1; step();
        chk("d5_idle", busy | done, 0);
        chk("d5_ab", aborted, 1);
        chk("d5_pulse", match_pulse, 0);
        chk("d5_cnt", match_count, 0);

        // reset mid-run restores defaults
        cfg(5'b00111, 3'd3, 0, 8'd3);
        do_start();
        bit_in(1); bit_in(1);
        rst = 1; step();
        chk("d6_busy", busy, 0);
        chk("d6_cnt", match_count, 0);
        do_start();
        for (int i = 4; i >= 0; i--) bit_in(s8[i]);
        chk("d6_defpat", done, 1);

`ifdef PDC_TIMEOUT_EN
        cfg(5'b11011, 3'd5, 1, 8'd1);
        do_start();
        for (int i = 0; i < 8; i++) bit_in(0);
        chk("d7_to", timeout, 1);
        chk("d7_done", done, 1);
        do_start();
        s8 = 8'b00011011;
        for (int i = 7; i >= 0; i--) bit_in(s8[i]);
        chk("d7_match_to", timeout, 0);
        chk("d7_match_cnt", match_count, 1);
        chk("d7_match_done", done, 1);
`endif

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 399) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            start      = ($urandom_range(0, 11) == 0);
            cfg_we     = ($urandom_range(0, 19) == 0);
            cfg_pattern = 5'($urandom);
            cfg_len    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7) & 7) - 3'($urandom_range(0, 1) * 6)
                                                    : 3'($urandom_range(1, 5));
            cfg_overlap = 1'($urandom);
            cfg_target = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            data_valid = ($urandom_range(0, 9) < 7);
            data_in    = 1'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
